// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared widths, blank segment pattern and scan FSM states
package seg_pkg;
  localparam int DIGIT_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;
  typedef enum logic {ST_GAP, ST_DRIVE} scan_state_t;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: host frame-load handshake channel
interface seg_scan_ctrl_if #(parameter int DIGITS = 4);
  logic load_valid;
  logic load_ready;
  logic [seg_pkg::DIGIT_W*DIGITS-1:0] load_data;
  logic [DIGITS-1:0] load_blank;
  modport master(output load_valid, load_data, load_blank, input load_ready);
  modport slave(input load_valid, load_data, load_blank, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl_indicator_7.sv
// indicator_7: hex code to {g,f,e,d,c,b,a} segment decoder
module indicator_7
  import seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [SEG_W-1:0]   seg
);
  always_comb begin
    case (code)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan with double-buffered frame and anti-ghost gap
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_ctrl_if.slave     load,
  output logic [DIGITS-1:0]  dig_sel,
  output logic [SEG_W-1:0]   seg,
  output logic               frame_done
);
  localparam int MAXC = DIV > BLANK_CYCLES ? DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  scan_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [DIGIT_W*DIGITS-1:0] pend_data, shadow, shadow_nxt;
  logic [DIGITS-1:0] pend_blank, shadow_blank, shadow_blank_nxt;
  logic pend_full, slot_end, boundary, swap, accept;
  logic [DIGIT_W-1:0] code;
  logic [SEG_W-1:0] dec;
  assign load.load_ready = !pend_full;
  // Outputs are registered from the next-state view, so the decoder sees the post-swap shadow.
  always_comb begin
    slot_end = state == ST_DRIVE && cnt == DIV_LAST;
    boundary = slot_end && idx == IDX_LAST;
    swap = boundary && pend_full;
    accept = load.load_valid && !pend_full;
    state_nxt = state;
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (state == ST_GAP && cnt == GAP_LAST) begin
      state_nxt = ST_DRIVE;
      cnt_nxt = '0;
    end else if (slot_end) begin
      state_nxt = BLANK_CYCLES == 0 ? ST_DRIVE : ST_GAP;
      cnt_nxt = '0;
      idx_nxt = boundary ? '0 : idx + 1'b1;
    end
    shadow_nxt = swap ? pend_data : shadow;
    shadow_blank_nxt = swap ? pend_blank : shadow_blank;
    code = shadow_nxt[idx_nxt*DIGIT_W +: DIGIT_W];
  end
  indicator_7 u_dec (.code(code), .seg(dec));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_GAP;
      cnt <= '0;
      idx <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_blank <= '0;
      shadow <= '0;
      shadow_blank <= '1;
      dig_sel <= '0;
      seg <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      shadow <= shadow_nxt;
      shadow_blank <= shadow_blank_nxt;
      pend_full <= accept || (pend_full && !swap);
      if (accept) begin
        pend_data <= load.load_data;
        pend_blank <= load.load_blank;
      end
      dig_sel <= state_nxt == ST_DRIVE ? DIGITS'(1) << idx_nxt : '0;
      seg <= state_nxt == ST_DRIVE && !shadow_blank_nxt[idx_nxt] ? dec : SEG_OFF;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed + random frames checked against a timeline-based scan model
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] dig_sel, dig_sel2;
  logic [6:0] seg, seg2;
  logic frame_done, frame_done2;
  int n_cmp = 0, n_bad = 0;
  int t;
  bit m_pend, m_fd, m_acc, m_swap;
  logic [15:0] m_pd, m_sh;
  logic [3:0] m_pb, m_sb;
  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seg_scan_ctrl_if #(.DIGITS(4)) ifc ();
  seg_scan_ctrl_if #(.DIGITS(4)) ifc2 ();
  seg_scan_ctrl #(.DIGITS(4), .DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(ifc), .dig_sel(dig_sel), .seg(seg), .frame_done(frame_done));
  seg_scan_ctrl #(.DIGITS(4), .DIV(1), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(ifc2), .dig_sel(dig_sel2), .seg(seg2), .frame_done(frame_done2));
  always #5 clk = ~clk;
  // Digit driven in cycle t after reset (-1 = dark); with no gap the reset cycle itself is dark.
  function automatic int slot_digit(int tt, int dv, int bc);
    int u = bc == 0 ? tt - 1 : tt;
    int p;
    if (u < 0) return -1;
    p = u % (4 * (bc + dv));
    return (p % (bc + dv)) >= bc ? p / (bc + dv) : -1;
  endfunction
  function automatic bit fd_at(int tt, int dv, int bc);
    int u = bc == 0 ? tt - 1 : tt;
    return u > 0 && u % (4 * (bc + dv)) == 0;
  endfunction
  function automatic logic [6:0] exp_seg(int d);
    if (d < 0 || m_sb[d]) return 7'h00;
    return tab[m_sh[4*d +: 4]];
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
    end
  endtask
  task automatic step();
    int d, d2;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_pend = 0; m_sh = '0; m_sb = '1; m_fd = 0; m_acc = 0;
    end else begin
      t++;
      m_fd = fd_at(t, 4, 1);
      m_swap = m_fd && m_pend;
      m_acc = ifc.load_valid && !m_pend;
      if (m_swap) begin m_sh = m_pd; m_sb = m_pb; end
      if (m_acc) begin m_pd = ifc.load_data; m_pb = ifc.load_blank; end
      m_pend = m_acc || (m_pend && !m_swap);
    end
    #1;
    d = slot_digit(t, 4, 1);
    d2 = slot_digit(t, 1, 0);
    chk("dig_sel", dig_sel, d < 0 ? 0 : 1 << d);
    chk("seg", seg, exp_seg(d));
    chk("frame_done", frame_done, m_fd);
    chk("load_ready", ifc.load_ready, !m_pend);
    chk("dig_sel2", dig_sel2, d2 < 0 ? 0 : 1 << d2);
    chk("seg2", seg2, 0);
    chk("frame_done2", frame_done2, rst_n && fd_at(t, 1, 0));
    chk("load_ready2", ifc2.load_ready, 1);
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic offer(logic [15:0] data, logic [3:0] blank);
    bit ok = 0;
    ifc.load_valid = 1; ifc.load_data = data; ifc.load_blank = blank;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      ok = m_acc;
    end
    ifc.load_valid = 0;
    chk("offer_accepted", ok, 1);
  endtask
  initial begin
    bit found;
    ifc.load_valid = 0; ifc.load_data = '0; ifc.load_blank = '0;
    ifc2.load_valid = 0; ifc2.load_data = '0; ifc2.load_blank = '0;
    rst_n = 0;
    run(2);
    rst_n = 1;
    run(45);
    offer(16'h3210, 4'b0000);
    run(45);
    offer(16'hA5C7, 4'b0010);
    offer(16'h9E1F, 4'b0000);
    run(50);
    offer(16'h8888, 4'b0100);
    run(45);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = m_fd;
    end
    chk("wait_boundary", found, 1);
    offer(16'h4567, 4'b0000);
    found = slot_digit(t, 4, 1) == 2;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = slot_digit(t, 4, 1) == 2 && m_pend;
    end
    chk("wait_digit2_pending", found, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    run(45);
    for (int i = 0; i < 400; i++) begin
      if (!ifc.load_valid && $urandom_range(0, 7) == 0) begin
        ifc.load_valid = 1;
        ifc.load_data = 16'($urandom);
        ifc.load_blank = 4'($urandom);
      end
      step();
      if (m_acc) ifc.load_valid = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
